fetch_stage: RTL

Front end of the pipeline: owns the PC register, drives the instruction-cache request, and holds the F/D pipeline register feeding decode. It consumes the stall/flush/redirect decisions from the hazard unit (`stall_F`, `stall_D`, `flush_D`, `pc_src`) and absorbs instruction-cache misses internally with a small FSM, inserting bubbles into D while a fill is outstanding.

---
 rtl/brisc_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage_fd_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 115 +++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared types and constants for the brisc pipeline.
package brisc_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_1000;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    // Next-PC source chosen by the hazard/branch logic.
    typedef enum logic {
        PC_PLUS4 = 1'b0,
        FROM_EX  = 1'b1
    } pc_src_e;

    // Fetch miss-handling FSM.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bundle between fetch and the I-cache.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            icache_req_out;
    logic [XLEN-1:0] icache_addr_out;
    logic            icache_ready_in;
    logic [31:0]     icache_instr_in;

    modport master (
        output icache_req_out,
        output icache_addr_out,
        input  icache_ready_in,
        input  icache_instr_in
    );

    modport slave (
        input  icache_req_out,
        input  icache_addr_out,
        output icache_ready_in,
        output icache_instr_in
    );
endinterface

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: flush beats stall beats load; non-delivered loads
// become NOP bubbles so decode never sees a stale word.
module fd_reg
    import brisc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            stall,
    input  logic            load_valid,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    // Register update with flush > stall > load priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (!stall) begin
            valid    <= load_valid;
            instr    <= load_valid ? load_instr : NOP_INSTR;
            pc       <= load_valid ? load_pc : '0;
            pc_plus4 <= load_valid ? load_pc + XLEN'(4) : '0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, I-cache request, miss FSM and the F/D register.
module fetch_stage
    import brisc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_F_in,
    input  logic               stall_D_in,
    input  logic               flush_D_in,
    input  pc_src_e            pc_src_in,
    input  logic [XLEN-1:0]    pc_target_EX_in,
    fetch_stage_if.master      icache,
    output logic [31:0]        instr_D_out,
    output logic [XLEN-1:0]    pc_D_out,
    output logic [XLEN-1:0]    pc_plus4_D_out,
    output logic               valid_D_out,
    output logic               miss_busy_out
);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] saved_target, saved_target_n;
    logic            deliver;
    logic            redirect;
    logic            ready;

    assign redirect = (pc_src_in == FROM_EX);
    assign ready    = icache.icache_ready_in;

    // The PC never moves while a miss is outstanding, so it is also the held
    // miss address in SQUASH; the redirect target waits in saved_target.
    assign icache.icache_req_out  = ~reset;
    assign icache.icache_addr_out = pc;
    assign miss_busy_out          = (state != RUN);

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            pc           <= RESET_PC;
            saved_target <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            saved_target <= saved_target_n;
        end
    end

    // Next-state, next-PC and delivery decision.
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        saved_target_n = saved_target;
        deliver        = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    if (ready) begin
                        pc_n = pc_target_EX_in;
                    end else begin
                        saved_target_n = pc_target_EX_in;
                        state_n        = SQUASH;
                    end
                end else if (!ready) begin
                    state_n = WAIT;
                end else if (!stall_F_in) begin
                    deliver = 1'b1;
                    pc_n    = pc + XLEN'(4);
                end
            end
            WAIT: begin
                if (redirect) begin
                    saved_target_n = pc_target_EX_in;
                    state_n        = SQUASH;
                end else if (ready) begin
                    state_n = RUN;
                    if (!stall_F_in && !stall_D_in) begin
                        deliver = 1'b1;
                        pc_n    = pc + XLEN'(4);
                    end
                end
            end
            SQUASH: begin
                if (redirect) begin
                    saved_target_n = pc_target_EX_in;
                end
                if (ready) begin
                    pc_n    = redirect ? pc_target_EX_in : saved_target;
                    state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    fd_reg #(.XLEN(XLEN)) u_fd_reg (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_D_in),
        .stall      (stall_D_in),
        .load_valid (deliver),
        .load_instr (icache.icache_instr_in),
        .load_pc    (pc),
        .valid      (valid_D_out),
        .instr      (instr_D_out),
        .pc         (pc_D_out),
        .pc_plus4   (pc_plus4_D_out)
    );

endmodule
